hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It sits in the ID stage and covers the hazards that EX-stage forwarding cannot resolve. It detects load-use and branch-operand hazards, stalls the front end for the required number of cycles, inserts bubbles into ID/EX, and flushes IF/ID on taken branches and jumps. It also honours a whole-pipeline freeze from the memory side and keeps a saturating stall-cycle counter.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_detect.sv | 42 ++++
 rtl/hazard_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// The register-match helper is the single definition of a source-operand dependence.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [1:0] NO_STALL       = 2'd0;
    localparam logic [1:0] STALL_LOAD_USE = 2'd1;
    localparam logic [1:0] STALL_BR_LOAD  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] src,
                                       input logic       uses);
        return (dst != REG_ZERO) && (dst == src) && uses;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// ID-stage hazard bundle: pipeline-side operand/control info in, stall/flush controls out.
// The pipeline is the master; the hazard controller is the slave.
interface hazard_if;

    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_is_branch;
    logic       id_redirect;
    logic       id_ex_memRead;
    logic       id_ex_regWrite;
    logic [4:0] id_ex_rd;
    logic       ex_mem_memRead;
    logic [4:0] ex_mem_rd;
    logic       mem_busy;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       pipe_freeze;

    modport master (
        output if_id_rs, if_id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_redirect,
               id_ex_memRead, id_ex_regWrite, id_ex_rd, ex_mem_memRead, ex_mem_rd, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
    );

    modport slave (
        input  if_id_rs, if_id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_redirect,
               id_ex_memRead, id_ex_regWrite, id_ex_rd, ex_mem_memRead, ex_mem_rd, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational stall-depth computation for the instruction currently in ID.
// A branch reading a load result still in EX needs two cycles; every other hazard needs one.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_branch,
    input  logic       id_ex_memRead,
    input  logic       id_ex_regWrite,
    input  logic [4:0] id_ex_rd,
    input  logic       ex_mem_memRead,
    input  logic [4:0] ex_mem_rd,
    output logic [1:0] need
);

    logic ex_hit;
    logic mem_hit;
    logic br_load;
    logic one_cycle;

    always_comb begin
        ex_hit    = reg_match(id_ex_rd, if_id_rs, id_uses_rs)
                  | reg_match(id_ex_rd, if_id_rt, id_uses_rt);
        mem_hit   = reg_match(ex_mem_rd, if_id_rs, id_uses_rs)
                  | reg_match(ex_mem_rd, if_id_rt, id_uses_rt);
        br_load   = id_is_branch & id_ex_memRead & ex_hit;
        one_cycle = (id_ex_memRead & ex_hit)
                  | (id_is_branch & id_ex_regWrite & ~id_ex_memRead & ex_hit)
                  | (id_is_branch & ex_mem_memRead & mem_hit);

        if (br_load)
            need = STALL_BR_LOAD;
        else if (one_cycle)
            need = STALL_LOAD_USE;
        else
            need = NO_STALL;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: stall/bubble/flush sequencing, memory freeze and stall statistics.
//   state | meaning
//   RUN   | normal issue; detection active, first bubble of any hazard issued here
//   STALL | forced bubbles remaining in cnt_q; detection ignored
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_if.slave          hz,
    output logic [CNT_W-1:0] stall_count
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic [1:0] need;

    hazard_detect u_detect (
        .if_id_rs       (hz.if_id_rs),
        .if_id_rt       (hz.if_id_rt),
        .id_uses_rs     (hz.id_uses_rs),
        .id_uses_rt     (hz.id_uses_rt),
        .id_is_branch   (hz.id_is_branch),
        .id_ex_memRead  (hz.id_ex_memRead),
        .id_ex_regWrite (hz.id_ex_regWrite),
        .id_ex_rd       (hz.id_ex_rd),
        .ex_mem_memRead (hz.ex_mem_memRead),
        .ex_mem_rd      (hz.ex_mem_rd),
        .need           (need)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // mem_busy freezes the sequencer so no pending bubble is lost or repeated.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!hz.mem_busy) begin
            case (state_q)
                RUN: begin
                    if (need != NO_STALL) begin
                        cnt_d   = need - 2'd1;
                        state_d = (need - 2'd1 != 2'd0) ? STALL : RUN;
                    end
                end
                STALL: begin
                    cnt_d   = cnt_q - 2'd1;
                    state_d = (cnt_q - 2'd1 == 2'd0) ? RUN : STALL;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        hz.pc_write     = 1'b0;
        hz.if_id_write  = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b1;
        hz.pipe_freeze  = 1'b0;
        if (rst_n) begin
            if (hz.mem_busy) begin
                hz.pipe_freeze  = 1'b1;
                hz.id_ex_bubble = 1'b0;
            end else if (state_q == RUN && need == NO_STALL) begin
                hz.pc_write     = 1'b1;
                hz.if_id_write  = 1'b1;
                hz.id_ex_bubble = 1'b0;
                hz.if_id_flush  = hz.id_redirect;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (hz.id_ex_bubble && (stall_count != '1))
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule
